// File: rtl/aes_ahb_queue_if.sv
// AHB-Lite register front end for an AES core: key registers, input/output block FIFOs
// and a sequencer that feeds queued plaintext blocks to the core one at a time.
//
// state  | meaning
// S_IDLE | waiting for ENABLE, a queued block and room for its result
// S_BUSY | core running; waiting for DONE to push the ciphertext
module aes_ahb_queue_if #(
  parameter int ADDR_W     = 8,
  parameter int KEY_WORDS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [ADDR_W-1:0]      HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic                   HREADY,
  input  logic [31:0]            HWDATA,
  output logic [31:0]            HRDATA,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic                   IRQ,
  output logic [32*KEY_WORDS-1:0] aes_key,
  output logic [127:0]           aes_plaintext,
  output logic                   start,
  input  logic [127:0]           aes_ciphertext,
  input  logic                   DONE
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                  state_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    write_q, valid_q;
  logic [31:0]             key_q [KEY_WORDS];
  logic [31:0]             stage_q [3];
  logic                    enable_q, irq_en_q;
  logic                    done_pend_q, ovf_q, unf_q;
  logic [127:0]            in_mem_q [FIFO_DEPTH];
  logic [127:0]            out_mem_q [FIFO_DEPTH];
  logic [PW-1:0]           in_wr_q, in_rd_q, out_wr_q, out_rd_q;
  logic [CW-1:0]           in_cnt_q, out_cnt_q, in_cnt_d, out_cnt_d;
  logic [127:0]            plaintext_q;
  logic [32*KEY_WORDS-1:0] key_snap_q;
  logic                    start_q;

  logic wr_en, rd_en, flush, st_wr, push_req, push_in, pop_in, push_out, pop_out, rd_c3;
  logic in_full, in_empty, out_full, out_empty, busy;
  logic [31:0] status;
  logic unused_ok;

  function automatic logic hit(input logic [ADDR_W-1:0] a, input int off);
    return a == ADDR_W'(off);
  endfunction

  assign wr_en     = valid_q & write_q;
  assign rd_en     = valid_q & ~write_q;
  assign busy      = (state_q == S_BUSY);
  assign in_full   = (in_cnt_q == CW'(FIFO_DEPTH));
  assign in_empty  = (in_cnt_q == '0);
  assign out_full  = (out_cnt_q == CW'(FIFO_DEPTH));
  assign out_empty = (out_cnt_q == '0);

  assign flush    = wr_en & hit(addr_q, 32'h20) & HWDATA[2];
  assign st_wr    = wr_en & hit(addr_q, 32'h24);
  assign pop_in   = ~busy & enable_q & ~in_empty & ~out_full;
  assign push_req = wr_en & hit(addr_q, 32'h3C) & ~flush;
  // A full FIFO still accepts the push when the sequencer frees a slot at the same edge.
  assign push_in  = push_req & (~in_full | pop_in);
  assign push_out = busy & DONE;
  assign rd_c3    = rd_en & hit(addr_q, 32'h4C);
  assign pop_out  = rd_c3 & ~out_empty;

  assign status = {8'h00, 8'(out_cnt_q), 8'(in_cnt_q), unf_q, ovf_q, done_pend_q,
                   out_empty, out_full, in_empty, in_full, busy};

  assign HREADYOUT     = 1'b1;
  assign HRESP         = 1'b0;
  assign IRQ           = irq_en_q & done_pend_q;
  assign aes_key       = key_snap_q;
  assign aes_plaintext = plaintext_q;
  assign start         = start_q;
  assign unused_ok     = HTRANS[0];

  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      for (int i = 0; i < KEY_WORDS; i++)
        if (hit(addr_q, 4 * i)) HRDATA = key_q[i];
      if (hit(addr_q, 32'h20)) HRDATA = {30'b0, irq_en_q, enable_q};
      if (hit(addr_q, 32'h24)) HRDATA = status;
      for (int i = 0; i < 4; i++)
        if (hit(addr_q, 32'h40 + 4 * i) && !out_empty) HRDATA = out_mem_q[out_rd_q][32*i +: 32];
    end
  end

  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (push_in & ~pop_in) in_cnt_d = in_cnt_q + CW'(1);
    else if (pop_in & ~push_in) in_cnt_d = in_cnt_q - CW'(1);
    if (push_out & ~pop_out) out_cnt_d = out_cnt_q + CW'(1);
    else if (pop_out & ~push_out) out_cnt_d = out_cnt_q - CW'(1);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      valid_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      done_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
      for (int i = 0; i < 3; i++) stage_q[i] <= '0;
    end else begin
      valid_q <= HSEL & HREADY & HTRANS[1];
      write_q <= HWRITE;
      addr_q  <= HADDR;
      if (wr_en) begin
        for (int i = 0; i < KEY_WORDS; i++)
          if (hit(addr_q, 4 * i)) key_q[i] <= HWDATA;
        if (hit(addr_q, 32'h20)) begin
          enable_q <= HWDATA[0];
          irq_en_q <= HWDATA[1];
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (flush) stage_q[i] <= '0;
        else if (wr_en && hit(addr_q, 32'h30 + 4 * i)) stage_q[i] <= HWDATA;
      end
      // Hardware set takes priority over a coincident write-1-to-clear.
      done_pend_q <= push_out | (done_pend_q & ~(st_wr & HWDATA[5]));
      ovf_q       <= (push_req & in_full & ~pop_in) | (ovf_q & ~(st_wr & HWDATA[6]));
      unf_q       <= (rd_c3 & out_empty) | (unf_q & ~(st_wr & HWDATA[7]));
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      in_cnt_q  <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        in_mem_q[i]  <= '0;
        out_mem_q[i] <= '0;
      end
    end else if (flush) begin
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      in_cnt_q  <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (push_in) begin
        in_mem_q[in_wr_q] <= {HWDATA, stage_q[2], stage_q[1], stage_q[0]};
        in_wr_q           <= in_wr_q + PW'(1);
      end
      if (pop_in) in_rd_q <= in_rd_q + PW'(1);
      if (push_out) begin
        out_mem_q[out_wr_q] <= aes_ciphertext;
        out_wr_q            <= out_wr_q + PW'(1);
      end
      if (pop_out) out_rd_q <= out_rd_q + PW'(1);
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      plaintext_q <= '0;
      key_snap_q  <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (pop_in) begin
          state_q     <= S_BUSY;
          start_q     <= 1'b1;
          plaintext_q <= in_mem_q[in_rd_q];
          for (int i = 0; i < KEY_WORDS; i++) key_snap_q[32*i +: 32] <= key_q[i];
        end
        S_BUSY: if (DONE) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
